axi_bram_responder: RTL and testbench
=====================================

AXI_BRAM_RESPONDER -- requirements
Module: axi_bram_responder

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 8, word address width; depth = 2^AXI_ADDR_WIDTH words.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 16, data word width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named axi_clk and axi_resetn.
REQ-004 axi_clk  input  1  sole clock, all state on rising edge.
REQ-005 axi_resetn  input  1  asynchronous active-low reset.
REQ-006 axi_awaddr  input  AXI_ADDR_WIDTH  write word address; axi_awvalid input 1; axi_awready output 1.
REQ-007 axi_wdata  input  AXI_DATA_WIDTH  write data; axi_wstrb input 1, whole-word enable; axi_wvalid input 1; axi_wready output 1.
REQ-008 axi_bresp  output  2  write response; axi_bvalid output 1; axi_bready input 1.
REQ-009 axi_araddr  input  AXI_ADDR_WIDTH  read word address; axi_arvalid input 1; axi_arready output 1.
REQ-010 axi_rdata  output  AXI_DATA_WIDTH  read data; axi_rresp output 2; axi_rvalid output 1; axi_rready input 1.

Function
REQ-011 Handshake SHALL complete on any rising edge with valid && ready both high; outputs SHALL hold stable while valid && !ready.
REQ-012 Write path SHALL be a 3-state FSM: W_IDLE (collect AW and W), W_WRITE (commit to memory), W_RESP (drive bvalid).
REQ-013 In W_IDLE, AW and W SHALL be accepted independently, either order or same cycle; each latched into its own holding register.
REQ-014 axi_awready SHALL be high only in W_IDLE with AW holding register empty; axi_wready likewise for W.
REQ-015 Once both holding registers are full, FSM SHALL enter W_WRITE next edge, write memory that cycle if axi_wstrb was 1, then enter W_RESP.
REQ-016 axi_wstrb = 0 SHALL complete normally with OKAY, memory unchanged.
REQ-017 W_RESP: axi_bvalid high, axi_bresp = OKAY (2'b00); on bready handshake return to W_IDLE with holding registers cleared.
REQ-018 Read path SHALL be a 3-state FSM: R_IDLE (arready high), R_READ (synchronous memory access), R_RESP (drive rvalid).
REQ-019 AR handshake at edge k SHALL produce axi_rvalid high after edge k+2; axi_rdata/axi_rresp (OKAY) valid and stable until rready handshake, then R_IDLE.
REQ-020 Read and write paths SHALL operate concurrently and independently; neither SHALL stall the other.
REQ-021 Same-address write commit and read access in the same cycle SHALL return the pre-write (old) data.
REQ-022 Address arithmetic SHALL be word-indexed, no byte offset; all addresses in range (full 2^AXI_ADDR_WIDTH decode).
REQ-023 Back-to-back: new AW/W SHALL be accepted the cycle after bready handshake; new AR the cycle after rready handshake.
REQ-024 Sustained throughput SHALL be one write per 3 cycles and one read per 3 cycles with ready masters.

Reset
REQ-025 axi_resetn low SHALL immediately force: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0; both FSMs idle; holding registers empty.
REQ-026 Ready outputs SHALL rise on the first edge after axi_resetn deasserts.
REQ-027 Reset mid-transaction SHALL abandon it with no response; an uncommitted write SHALL not modify memory; memory contents need not be cleared.

Structure
REQ-028 AXI response codes (OKAY 2'b00, SLVERR 2'b10) SHALL live in a shared AXI constants include used by all AXI blocks.
REQ-029 Storage SHALL be one sub-module, bram_sdp: simple dual-port synchronous RAM, one write port, one registered read port, inferable as iCE40 EBR.
REQ-030 FSM state encodings SHALL be local parameters of this module.

Verification
REQ-031 AW then W two cycles later, addr 0x12, data 0xA5A5 -> single bvalid, bresp 00; later AR 0x12 -> rdata 0xA5A5 two edges after handshake.
REQ-032 AW and W same cycle, wstrb 0, addr 0x05 preloaded 0x1234 -> bresp 00; read 0x05 returns 0x1234.
REQ-033 bready held low 5 cycles -> bvalid and bresp stable, awready/wready low throughout; no second write accepted.
REQ-034 Write 0xBEEF to 0x20 (old 0x0000) with commit cycle coinciding with read access of 0x20 -> read returns 0x0000; next read returns 0xBEEF.
REQ-035 axi_resetn pulsed low while rvalid high -> rvalid 0 immediately, all readies 1 on first edge after release.
REQ-036 Random concurrent write/read traffic over all 256 addresses against a scoreboard -> zero mismatches, every response OKAY.

Source files
------------

// File: rtl/axi_bram_responder_pkg.sv
// Shared AXI constants and helpers for the AXI-attached BRAM blocks.
// Response codes sit here so every AXI block agrees on the same encodings.
package axi_bram_responder_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // A channel beat transfers on any rising edge that sees both sides high.
   function automatic logic axiHandshake(input logic valid, input logic ready);
      return valid & ready;
   endfunction

endpackage

// File: rtl/axi_bram_responder_bram_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Read-before-write on a same-address collision, matching iCE40 EBR behaviour.
module bram_sdp #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  wrEn_i,
   input  logic [ADDR_WIDTH-1:0] wrAddr_i,
   input  logic [DATA_WIDTH-1:0] wrData_i,
   input  logic                  rdEn_i,
   input  logic [ADDR_WIDTH-1:0] rdAddr_i,
   output logic [DATA_WIDTH-1:0] rdData_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rdData_q;

   // No reset on the array or read register so the tools can map both into block RAM.
   always_ff @(posedge clk_i) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
      if (rdEn_i) begin
         rdData_q <= mem_q[rdAddr_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/axi_bram_responder.sv
// AXI-style word-addressed responder in front of a simple dual-port BRAM.
// Independent write and read FSMs, each completing one transfer every three cycles.
module axi_bram_responder
   import axi_bram_responder_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int AXI_DATA_WIDTH = 16
) (
   input  logic                      axi_clk,
   input  logic                      axi_resetn,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
   input  logic                      axi_awvalid,
   output logic                      axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
   input  logic                      axi_wstrb,
   input  logic                      axi_wvalid,
   output logic                      axi_wready,
   output logic [1:0]                axi_bresp,
   output logic                      axi_bvalid,
   input  logic                      axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
   input  logic                      axi_arvalid,
   output logic                      axi_arready,
   output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
   output logic [1:0]                axi_rresp,
   output logic                      axi_rvalid,
   input  logic                      axi_rready
);

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_WRITE = 2'd1,
      W_RESP  = 2'd2
   } wrState_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_READ = 2'd1,
      R_RESP = 2'd2
   } rdState_e;

   wrState_e                  wrState_q;
   logic                      awFull_q;
   logic                      wFull_q;
   logic                      awFull_d;
   logic                      wFull_d;
   logic [AXI_ADDR_WIDTH-1:0] awAddr_q;
   logic [AXI_DATA_WIDTH-1:0] wData_q;
   logic                      wStrb_q;
   logic                      awReady_q;
   logic                      wReady_q;
   logic                      bValid_q;
   logic [1:0]                bResp_q;

   rdState_e                  rdState_q;
   logic [AXI_ADDR_WIDTH-1:0] arAddr_q;
   logic                      arReady_q;
   logic                      rValid_q;
   logic [1:0]                rResp_q;

   logic                      awHs;
   logic                      wHs;
   logic                      bHs;
   logic                      arHs;
   logic                      rHs;
   logic                      ramWrEn;
   logic                      ramRdEn;
   logic [AXI_DATA_WIDTH-1:0] ramRdData;

   assign awHs = axiHandshake(axi_awvalid, awReady_q);
   assign wHs  = axiHandshake(axi_wvalid, wReady_q);
   assign bHs  = axiHandshake(bValid_q, axi_bready);
   assign arHs = axiHandshake(axi_arvalid, arReady_q);
   assign rHs  = axiHandshake(rValid_q, axi_rready);

   always_comb begin
      awFull_d = awFull_q | awHs;
      wFull_d  = wFull_q | wHs;
   end

   // Write FSM: AW and W fill their own holding registers in any order; once both
   // are full the readies drop, the commit cycle follows and then the B response.
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wrState_q <= W_IDLE;
         awFull_q  <= 1'b0;
         wFull_q   <= 1'b0;
         awAddr_q  <= '0;
         wData_q   <= '0;
         wStrb_q   <= 1'b0;
         awReady_q <= 1'b0;
         wReady_q  <= 1'b0;
         bValid_q  <= 1'b0;
         bResp_q   <= AXI_RESP_OKAY;
      end else begin
         case (wrState_q)
            W_IDLE: begin
               if (awHs) begin
                  awAddr_q <= axi_awaddr;
               end
               if (wHs) begin
                  wData_q <= axi_wdata;
                  wStrb_q <= axi_wstrb;
               end
               awFull_q <= awFull_d;
               wFull_q  <= wFull_d;
               if (awFull_d && wFull_d) begin
                  wrState_q <= W_WRITE;
                  awReady_q <= 1'b0;
                  wReady_q  <= 1'b0;
               end else begin
                  awReady_q <= ~awFull_d;
                  wReady_q  <= ~wFull_d;
               end
            end
            W_WRITE: begin
               wrState_q <= W_RESP;
               bValid_q  <= 1'b1;
               bResp_q   <= AXI_RESP_OKAY;
            end
            W_RESP: begin
               if (bHs) begin
                  wrState_q <= W_IDLE;
                  bValid_q  <= 1'b0;
                  awFull_q  <= 1'b0;
                  wFull_q   <= 1'b0;
                  awReady_q <= 1'b1;
                  wReady_q  <= 1'b1;
               end
            end
            default: begin
               wrState_q <= W_IDLE;
            end
         endcase
      end
   end

   // Read FSM: the RAM is accessed in R_READ, so its registered output is ready
   // exactly when rvalid rises in R_RESP.
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         rdState_q <= R_IDLE;
         arAddr_q  <= '0;
         arReady_q <= 1'b0;
         rValid_q  <= 1'b0;
         rResp_q   <= AXI_RESP_OKAY;
      end else begin
         case (rdState_q)
            R_IDLE: begin
               if (arHs) begin
                  arAddr_q  <= axi_araddr;
                  arReady_q <= 1'b0;
                  rdState_q <= R_READ;
               end else begin
                  arReady_q <= 1'b1;
               end
            end
            R_READ: begin
               rdState_q <= R_RESP;
               rValid_q  <= 1'b1;
               rResp_q   <= AXI_RESP_OKAY;
            end
            R_RESP: begin
               if (rHs) begin
                  rdState_q <= R_IDLE;
                  rValid_q  <= 1'b0;
                  arReady_q <= 1'b1;
               end
            end
            default: begin
               rdState_q <= R_IDLE;
            end
         endcase
      end
   end

   assign ramWrEn = (wrState_q == W_WRITE) && wStrb_q;
   assign ramRdEn = (rdState_q == R_READ);

   bram_sdp #(
      .ADDR_WIDTH(AXI_ADDR_WIDTH),
      .DATA_WIDTH(AXI_DATA_WIDTH)
   ) uBram (
      .clk_i   (axi_clk),
      .wrEn_i  (ramWrEn),
      .wrAddr_i(awAddr_q),
      .wrData_i(wData_q),
      .rdEn_i  (ramRdEn),
      .rdAddr_i(arAddr_q),
      .rdData_o(ramRdData)
   );

   // The RAM read register has no reset, so the data bus is masked outside a response.
   assign axi_rdata   = rValid_q ? ramRdData : '0;
   assign axi_rresp   = rResp_q;
   assign axi_rvalid  = rValid_q;
   assign axi_arready = arReady_q;
   assign axi_awready = awReady_q;
   assign axi_wready  = wReady_q;
   assign axi_bvalid  = bValid_q;
   assign axi_bresp   = bResp_q;

endmodule

// File: tb/tb_axi_bram_responder.sv
// Scoreboard bench for axi_bram_responder: drivers issue AXI traffic, a negedge
// monitor keeps a word-array model of memory and checks every B and R beat.
module tb_axi_bram_responder;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          axi_clk = 1'b0;
   logic          axi_resetn = 1'b0;
   logic [AW-1:0] axi_awaddr = '0;
   logic          axi_awvalid = 1'b0;
   logic          axi_awready;
   logic [DW-1:0] axi_wdata = '0;
   logic          axi_wstrb = 1'b0;
   logic          axi_wvalid = 1'b0;
   logic          axi_wready;
   logic [1:0]    axi_bresp;
   logic          axi_bvalid;
   logic          axi_bready = 1'b0;
   logic [AW-1:0] axi_araddr = '0;
   logic          axi_arvalid = 1'b0;
   logic          axi_arready;
   logic [DW-1:0] axi_rdata;
   logic [1:0]    axi_rresp;
   logic          axi_rvalid;
   logic          axi_rready = 1'b0;

   always #5 axi_clk = ~axi_clk;

   axi_bram_responder #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
      .axi_clk    (axi_clk),
      .axi_resetn (axi_resetn),
      .axi_awaddr (axi_awaddr),
      .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready),
      .axi_wdata  (axi_wdata),
      .axi_wstrb  (axi_wstrb),
      .axi_wvalid (axi_wvalid),
      .axi_wready (axi_wready),
      .axi_bresp  (axi_bresp),
      .axi_bvalid (axi_bvalid),
      .axi_bready (axi_bready),
      .axi_araddr (axi_araddr),
      .axi_arvalid(axi_arvalid),
      .axi_arready(axi_arready),
      .axi_rdata  (axi_rdata),
      .axi_rresp  (axi_rresp),
      .axi_rvalid (axi_rvalid),
      .axi_rready (axi_rready)
   );

   int total = 0;
   int bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a plain word array. A write whose AW and W are both in by
   // edge e lands at edge e+1; a read accepted at edge a samples memory at edge a+1,
   // before any write landing on that same edge.
   typedef struct {
      int            at;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          strb;
   } wrEv_t;

   typedef struct {
      int            at;
      logic [AW-1:0] addr;
   } rdEv_t;

   logic [DW-1:0] modelMem [256];
   wrEv_t         pendWr[$];
   rdEv_t         pendRd[$];
   logic [DW-1:0] rExp[$];
   int            bExp = 0;
   int            cyc = 0;
   int            arHsEdge = -1;
   int            bHsEdges[$];
   int            rHsEdges[$];
   logic          awHeld = 1'b0, wHeld = 1'b0, heldStrb = 1'b0;
   logic [AW-1:0] heldAddr = '0;
   logic [DW-1:0] heldData = '0;
   logic          bHold = 1'b0, rHold = 1'b0;
   logic [1:0]    bRespHold = '0, rRespHold = '0;
   logic [DW-1:0] rDataHold = '0;

   initial begin
      for (int i = 0; i < 256; i++) modelMem[i] = '0;
   end

   // Monitor: negedge N looks ahead to rising edge N, when inputs and registered outputs are settled.
   always @(negedge axi_clk) begin
      logic [DW-1:0] expData;
      cyc++;
      if (!axi_resetn) begin
         pendWr.delete();
         pendRd.delete();
         rExp.delete();
         bExp = 0;
         arHsEdge = -1;
         awHeld = 1'b0;
         wHeld = 1'b0;
         bHold = 1'b0;
         rHold = 1'b0;
      end else begin
         while (pendRd.size() > 0 && pendRd[0].at == cyc) begin
            rExp.push_back(modelMem[pendRd[0].addr]);
            void'(pendRd.pop_front());
         end
         while (pendWr.size() > 0 && pendWr[0].at == cyc) begin
            if (pendWr[0].strb) modelMem[pendWr[0].addr] = pendWr[0].data;
            bExp++;
            void'(pendWr.pop_front());
         end
         if (bHold) begin
            checkOutput("bvalid_hold", axi_bvalid, 1);
            checkOutput("bresp_hold", axi_bresp, bRespHold);
         end
         if (rHold) begin
            checkOutput("rvalid_hold", axi_rvalid, 1);
            checkOutput("rdata_hold", axi_rdata, rDataHold);
            checkOutput("rresp_hold", axi_rresp, rRespHold);
         end
         if (arHsEdge >= 0 && cyc == arHsEdge + 1) checkOutput("rvalid_early", axi_rvalid, 0);
         if (arHsEdge >= 0 && cyc == arHsEdge + 2) begin
            checkOutput("rvalid_latency", axi_rvalid, 1);
            arHsEdge = -1;
         end
         if (axi_awvalid && axi_awready) begin
            awHeld = 1'b1;
            heldAddr = axi_awaddr;
         end
         if (axi_wvalid && axi_wready) begin
            wHeld = 1'b1;
            heldData = axi_wdata;
            heldStrb = axi_wstrb;
         end
         if (awHeld && wHeld) begin
            pendWr.push_back('{cyc + 1, heldAddr, heldData, heldStrb});
            awHeld = 1'b0;
            wHeld = 1'b0;
         end
         if (axi_arvalid && axi_arready) begin
            pendRd.push_back('{cyc + 1, axi_araddr});
            arHsEdge = cyc;
         end
         if (axi_bvalid && axi_bready) begin
            checkOutput("b_outstanding", (bExp > 0), 1);
            if (bExp > 0) bExp--;
            checkOutput("bresp", axi_bresp, 0);
            bHsEdges.push_back(cyc);
         end
         if (axi_rvalid && axi_rready) begin
            checkOutput("r_outstanding", (rExp.size() > 0), 1);
            if (rExp.size() > 0) begin
               expData = rExp.pop_front();
               checkOutput("rdata", axi_rdata, expData);
            end
            checkOutput("rresp", axi_rresp, 0);
            rHsEdges.push_back(cyc);
         end
         bHold = axi_bvalid && !axi_bready;
         bRespHold = axi_bresp;
         rHold = axi_rvalid && !axi_rready;
         rDataHold = axi_rdata;
         rRespHold = axi_rresp;
      end
   end

   task automatic sendAw(input logic [AW-1:0] a, input int dly);
      logic ok = 1'b0;
      repeat (dly) @(posedge axi_clk);
      #1;
      axi_awaddr = a;
      axi_awvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge axi_clk);
         if (axi_awready) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("aw_handshake", ok, 1);
      @(posedge axi_clk);
      #1;
      axi_awvalid = 1'b0;
   endtask

   task automatic sendW(input logic [DW-1:0] d, input logic s, input int dly);
      logic ok = 1'b0;
      repeat (dly) @(posedge axi_clk);
      #1;
      axi_wdata = d;
      axi_wstrb = s;
      axi_wvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge axi_clk);
         if (axi_wready) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("w_handshake", ok, 1);
      @(posedge axi_clk);
      #1;
      axi_wvalid = 1'b0;
   endtask

   task automatic sendAr(input logic [AW-1:0] a, input int dly);
      logic ok = 1'b0;
      repeat (dly) @(posedge axi_clk);
      #1;
      axi_araddr = a;
      axi_arvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge axi_clk);
         if (axi_arready) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("ar_handshake", ok, 1);
      @(posedge axi_clk);
      #1;
      axi_arvalid = 1'b0;
   endtask

   task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s,
                          input int awDly, input int wDly, input int bDly);
      logic ok = 1'b0;
      if (bDly == 0) axi_bready = 1'b1;
      fork
         sendAw(a, awDly);
         sendW(d, s, wDly);
      join
      for (int i = 0; i < 50; i++) begin
         @(negedge axi_clk);
         if (axi_bvalid) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("b_arrives", ok, 1);
      if (bDly > 0) begin
         for (int k = 0; k < bDly; k++) begin
            checkOutput("awready_during_b", axi_awready, 0);
            checkOutput("wready_during_b", axi_wready, 0);
            @(posedge axi_clk);
            #1;
         end
         axi_bready = 1'b1;
         @(negedge axi_clk);
      end
      @(posedge axi_clk);
      #1;
      axi_bready = 1'b0;
   endtask

   task automatic doRead(input logic [AW-1:0] a, input int arDly, input int rDly, output logic [DW-1:0] got);
      logic ok = 1'b0;
      if (rDly == 0) axi_rready = 1'b1;
      sendAr(a, arDly);
      for (int i = 0; i < 50; i++) begin
         @(negedge axi_clk);
         if (axi_rvalid) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("r_arrives", ok, 1);
      if (rDly > 0) begin
         repeat (rDly) begin
            @(posedge axi_clk);
            #1;
         end
         axi_rready = 1'b1;
         @(negedge axi_clk);
      end
      got = axi_rdata;
      @(posedge axi_clk);
      #1;
      axi_rready = 1'b0;
   endtask

   // Random concurrent traffic: independent write and read streams over the whole address space.
   task automatic applyStimulus(input int nWr, input int nRd);
      fork
         begin
            for (int i = 0; i < nWr; i++) begin
               doWrite(AW'($urandom_range(0, 255)), DW'($urandom), ($urandom_range(0, 7) != 0),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end
         end
         begin
            logic [DW-1:0] g;
            for (int i = 0; i < nRd; i++) begin
               doRead(AW'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 2), g);
            end
         end
      join
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_awready"}, axi_awready, 0);
      checkOutput({tag, "_wready"}, axi_wready, 0);
      checkOutput({tag, "_arready"}, axi_arready, 0);
      checkOutput({tag, "_bvalid"}, axi_bvalid, 0);
      checkOutput({tag, "_rvalid"}, axi_rvalid, 0);
      checkOutput({tag, "_bresp"}, axi_bresp, 0);
      checkOutput({tag, "_rresp"}, axi_rresp, 0);
      checkOutput({tag, "_rdata"}, axi_rdata, 0);
   endtask

   task automatic checkReadiesHigh(input string tag);
      checkOutput({tag, "_awready"}, axi_awready, 1);
      checkOutput({tag, "_wready"}, axi_wready, 1);
      checkOutput({tag, "_arready"}, axi_arready, 1);
   endtask

   initial begin
      logic [DW-1:0] got;
      logic ok;

      #2;
      checkResetOutputs("reset");
      repeat (3) @(posedge axi_clk);
      #2;
      axi_resetn = 1'b1;
      @(negedge axi_clk);
      checkOutput("pre_edge_awready", axi_awready, 0);
      @(posedge axi_clk);
      #1;
      checkReadiesHigh("first_edge");

      for (int a = 0; a < 256; a++) doWrite(AW'(a), '0, 1'b1, 0, 0, 0);

      $display("[TB] AW then W two cycles later");
      doWrite(8'h12, 16'hA5A5, 1'b1, 0, 2, 0);
      doRead(8'h12, 0, 0, got);
      checkOutput("read_0x12", got, 16'hA5A5);

      $display("[TB] wstrb=0 leaves memory unchanged");
      doWrite(8'h05, 16'h1234, 1'b1, 0, 0, 0);
      doWrite(8'h05, 16'hFFFF, 1'b0, 0, 0, 0);
      doRead(8'h05, 0, 0, got);
      checkOutput("read_0x05", got, 16'h1234);

      $display("[TB] bready held low");
      doWrite(8'h40, 16'h5555, 1'b1, 0, 0, 5);

      $display("[TB] back-to-back throughput");
      doWrite(8'h41, 16'h0101, 1'b1, 0, 0, 0);
      doWrite(8'h42, 16'h0202, 1'b1, 0, 0, 0);
      checkOutput("write_interval", bHsEdges[bHsEdges.size()-1] - bHsEdges[bHsEdges.size()-2], 3);
      doRead(8'h41, 0, 0, got);
      doRead(8'h42, 0, 0, got);
      checkOutput("read_0x42", got, 16'h0202);
      checkOutput("read_interval", rHsEdges[rHsEdges.size()-1] - rHsEdges[rHsEdges.size()-2], 3);

      $display("[TB] same-cycle write commit and read access");
      fork
         doWrite(8'h20, 16'hBEEF, 1'b1, 0, 0, 0);
         doRead(8'h20, 0, 0, got);
      join
      checkOutput("collide_old", got, 16'h0000);
      doRead(8'h20, 0, 0, got);
      checkOutput("collide_new", got, 16'hBEEF);

      $display("[TB] reset while rvalid high");
      axi_rready = 1'b0;
      sendAr(8'h12, 0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge axi_clk);
         if (axi_rvalid) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("rvalid_before_reset", ok, 1);
      @(posedge axi_clk);
      #2;
      axi_resetn = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(posedge axi_clk);
      #2;
      axi_resetn = 1'b1;
      @(negedge axi_clk);
      checkOutput("release_arready", axi_arready, 0);
      @(posedge axi_clk);
      #1;
      checkReadiesHigh("after_release");
      doRead(8'h12, 0, 0, got);
      checkOutput("read_after_reset", got, 16'hA5A5);

      $display("[TB] random concurrent traffic");
      applyStimulus(150, 150);

      repeat (5) @(negedge axi_clk);
      checkOutput("r_drained", rExp.size(), 0);
      checkOutput("b_drained", bExp, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
